uart_tx_arbiter: RTL

//  Shares the single UART transmitter (tx_data/new_tx_data/tx_busy) among NUM_REQ message sources.

---
 rtl/uart_arb_pkg.sv | 24 ++
 rtl/rr_picker.sv | 46 ++++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | uart_arb_pkg : state encoding and shared constants, uart_tx_arbiter |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package uart_arb_pkg;

  localparam int ARB_MAX_REQ = 8;
  localparam int BYTE_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // Index width for a requester vector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | rr_picker : round-robin pick of the first request after last_grant  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               any,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  int                   start;
  int                   pos;

  always_comb begin
    start   = (int'(last_grant) + 1) % NUM_REQ;
    req_dbl = {req, req};
    req_rot = NUM_REQ'(req_dbl >> start);
    any     = 1'b0;
    pos     = 0;
    // Descending scan so the lowest rotated offset is the one that sticks.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        any = 1'b1;
        pos = start + k;
      end
    end
    if (pos >= NUM_REQ) begin
      pos = pos - NUM_REQ;
    end
    idx    = IDX_W'(pos);
    onehot = any ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | uart_tx_arbiter : message-granular round-robin share of one UART tx |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      new_tx_data,
  input  logic                      tx_busy,
  output logic                      timeout
);

  localparam int               IDX_W    = idx_w(NUM_REQ);
  localparam int               TMR_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic               new_tx_data_q, new_tx_data_d;
  logic               timeout_q, timeout_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               msg_end_q, msg_end_d;

  logic               pick_any;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;

  // last_grant_q doubles as the owner index while grant_q is non-zero.
  logic               own_valid;
  logic               own_last;
  logic [BYTE_W-1:0]  own_data;

  assign own_valid = req_valid[last_grant_q];
  assign own_last  = req_last[last_grant_q];
  assign own_data  = req_data[last_grant_q*BYTE_W +: BYTE_W];

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .any        (pick_any),
    .onehot     (pick_onehot),
    .idx        (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      last_grant_q  <= IDX_W'(NUM_REQ - 1);
      tx_data_q     <= '0;
      new_tx_data_q <= 1'b0;
      timeout_q     <= 1'b0;
      timer_q       <= '0;
      msg_end_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      tx_data_q     <= tx_data_d;
      new_tx_data_q <= new_tx_data_d;
      timeout_q     <= timeout_d;
      timer_q       <= timer_d;
      msg_end_q     <= msg_end_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    tx_data_d     = tx_data_q;
    new_tx_data_d = 1'b0;
    timeout_d     = 1'b0;
    timer_d       = timer_q;
    msg_end_d     = msg_end_q;
    req_ready     = '0;

    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (pick_any) begin
          grant_d      = pick_onehot;
          last_grant_d = pick_idx;
          state_d      = ST_OWN;
        end
      end

      ST_OWN: begin
        // A busy UART freezes everything here, including the stall watchdog.
        if (!tx_busy) begin
          req_ready = grant_q & req_valid;
          if (own_valid) begin
            tx_data_d     = own_data;
            new_tx_data_d = 1'b1;
            msg_end_d     = own_last;
            timer_d       = '0;
            state_d       = ST_GAP;
          end else if (TIMEOUT != 0) begin
            if (timer_q == TMR_LAST) begin
              grant_d   = '0;
              timeout_d = 1'b1;
              timer_d   = '0;
              state_d   = ST_IDLE;
            end else begin
              timer_d = timer_q + TMR_W'(1);
            end
          end
        end
      end

      ST_GAP: begin
        if (msg_end_q) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OWN;
        end
      end

      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_data_q;
  assign timeout     = timeout_q;

endmodule
`default_nettype wire
